bip_control_unit: RTL and testbench
===================================

// Module: bip_control_unit
// PURPOSE
//  Sequencer/decoder for the BIP1 accumulator datapath. Fetches 16-bit instructions
//  from program ROM (PC addressed), decodes opcode, drives datapath mux/ALU/accumulator
//  and data-RAM strobes. Runs a 3-state instruction cycle and halts on HLT.
//  Sits between program ROM, data RAM and the datapath in the BIP1 top level.
// PARAMETERS
//  NB_INSTR   16  instruction width ({opcode, operand})
//  NB_OPCODE  5   opcode field width, instr[15:11]
//  NB_OPERAND 11  operand field width, instr[10:0]
//  NB_ADDR    11  program counter width
//  NB_CYCLES  32  cycle counter width
// PORTS
//  i_clk      in   1           clock, all state on rising edge
//  i_rst      in   1           synchronous, active-low reset
//  i_start    in   1           level; leaves IDLE when 1
//  i_instr    in   NB_INSTR    ROM data; registered ROM, valid 1 cycle after o_pc
//  o_pc       out  NB_ADDR     program ROM address (PC register)
//  o_operand  out  NB_OPERAND  IR[10:0]; datapath operand and data-RAM address
//  o_SelA     out  2           datapath mux A: 00 RAM, 01 sign-ext, 10 ALU
//  o_SelB     out  1           datapath mux B: 0 RAM, 1 sign-ext
//  o_op       out  1           ALU: 0 add, 1 subtract
//  o_WrAcc    out  1           accumulator write enable
//  o_WrRam    out  1           data RAM write strobe (data = ACC)
//  o_RdRam    out  1           data RAM read enable (async-read RAM)
//  o_halt     out  1           1 while in HALT
//  o_illegal  out  1           1-cycle pulse on undefined opcode in EXEC
//  o_cycles   out  NB_CYCLES   clocks spent executing
// BEHAVIOUR
//  Reset (i_rst=0 at edge): state=IDLE, PC=0, IR=0, o_cycles=0. All outputs 0.
//   Holds from any state, including mid-instruction.
//  FSM: IDLE -> FETCH when i_start=1, else stay. FETCH -> DECODE -> EXEC.
//   EXEC -> FETCH, or EXEC -> HALT if IR opcode = HLT. HALT is terminal until reset;
//   i_start is ignored outside IDLE.
//  FETCH: o_pc=PC; ROM registers word at end of cycle.
//  DECODE: IR <= i_instr at end of cycle.
//  EXEC: decoded controls asserted for exactly this cycle. PC <= PC+1 at end of cycle,
//   except HLT (PC holds). PC wraps 2^NB_ADDR-1 -> 0.
//  Controls are combinational from state and IR; all 0 outside EXEC. 3 clocks/instr.
//  Decode table (opcode: SelA SelB op WrAcc WrRam RdRam):
//   00000 HLT : 00 0 0 0 0 0 -> HALT
//   00001 STO : 00 0 0 0 1 0
//   00010 LD  : 00 0 0 1 0 1
//   00011 LDI : 01 0 0 1 0 0
//   00100 ADD : 10 0 0 1 0 1
//   00101 ADDI: 10 1 0 1 0 0
//   00110 SUB : 10 0 1 1 0 1
//   00111 SUBI: 10 1 1 1 0 0
//   others    : all 0 (NOP), o_illegal=1 this cycle, PC increments
//  o_halt=1 from the cycle after HLT's EXEC.
//  o_cycles increments every clock in FETCH/DECODE/EXEC. Saturates at all-ones.
//  Frozen in IDLE/HALT.
//  o_operand = IR[10:0] in every state; sign extension is the datapath's job.
// TESTING
//  1 Reset: hold i_rst=0 3 clks, i_start=1 -> state IDLE, o_pc=0, all controls 0,
//    o_cycles=0.
//  2 Program LDI 5; ADDI 3; STO 7; HLT, i_start=1 -> EXECs on clocks 3,6,9,12.
//    LDI: SelA=01 WrAcc=1. ADDI: SelA=10 SelB=1 op=0. STO: WrRam=1, o_operand=7.
//    Then o_halt=1, o_pc=3, o_cycles=12; RAM[7]=8 with datapath attached.
//  3 i_start=0 for 10 clks after reset -> o_pc=0, o_cycles=0; FETCH on first clock
//    with i_start=1.
//  4 PC preloaded to 2047 via NOP run (ADDI 0 everywhere) -> after EXEC at 2047,
//    o_pc=0, no halt.
//  5 Opcode 11111 -> o_illegal=1 for one clock in EXEC, WrAcc/WrRam=0, next FETCH
//    at PC+1.
//  6 i_rst=0 during EXEC of SUB -> next clock IDLE, o_WrAcc=0, o_pc=0, o_cycles=0.

Source files
------------

// File: rtl/bip_control_unit_if.sv
// Bus between the BIP1 control unit and its ROM/datapath side.
// The master modport is the control unit; the slave modport is the ROM/datapath side.
interface bip_control_unit_if #(
  parameter int NB_INSTR   = 16,
  parameter int NB_OPERAND = 11,
  parameter int NB_ADDR    = 11,
  parameter int NB_CYCLES  = 32
);
  logic                  i_start;
  logic [NB_INSTR-1:0]   i_instr;
  logic [NB_ADDR-1:0]    o_pc;
  logic [NB_OPERAND-1:0] o_operand;
  logic [1:0]            o_SelA;
  logic                  o_SelB;
  logic                  o_op;
  logic                  o_WrAcc;
  logic                  o_WrRam;
  logic                  o_RdRam;
  logic                  o_halt;
  logic                  o_illegal;
  logic [NB_CYCLES-1:0]  o_cycles;

  modport master (
    input  i_start, i_instr,
    output o_pc, o_operand, o_SelA, o_SelB, o_op, o_WrAcc, o_WrRam, o_RdRam,
           o_halt, o_illegal, o_cycles
  );

  modport slave (
    output i_start, i_instr,
    input  o_pc, o_operand, o_SelA, o_SelB, o_op, o_WrAcc, o_WrRam, o_RdRam,
           o_halt, o_illegal, o_cycles
  );
endinterface

// File: rtl/bip_control_unit.sv
// BIP1 sequencer/decoder: FETCH -> DECODE -> EXEC instruction cycle, halts on HLT.
// Datapath controls are decoded from IR and are live only in EXEC.
module bip_control_unit #(
  parameter int NB_INSTR   = 16,
  parameter int NB_OPCODE  = 5,
  parameter int NB_OPERAND = 11,
  parameter int NB_ADDR    = 11,
  parameter int NB_CYCLES  = 32
) (
  input  logic               i_clk,
  input  logic               i_rst,
  bip_control_unit_if.master bus
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_HALT   = 3'd4
  } state_t;

  localparam logic [NB_OPCODE-1:0] OP_HLT  = 5'b00000;
  localparam logic [NB_OPCODE-1:0] OP_STO  = 5'b00001;
  localparam logic [NB_OPCODE-1:0] OP_LD   = 5'b00010;
  localparam logic [NB_OPCODE-1:0] OP_LDI  = 5'b00011;
  localparam logic [NB_OPCODE-1:0] OP_ADD  = 5'b00100;
  localparam logic [NB_OPCODE-1:0] OP_ADDI = 5'b00101;
  localparam logic [NB_OPCODE-1:0] OP_SUB  = 5'b00110;
  localparam logic [NB_OPCODE-1:0] OP_SUBI = 5'b00111;

  localparam logic [1:0] SELA_RAM = 2'b00;
  localparam logic [1:0] SELA_IMM = 2'b01;
  localparam logic [1:0] SELA_ALU = 2'b10;

  state_t                state_q, state_d;
  logic [NB_ADDR-1:0]    pc_q, pc_d;
  logic [NB_INSTR-1:0]   ir_q, ir_d;
  logic [NB_CYCLES-1:0]  cycles_q, cycles_d;

  logic [NB_OPCODE-1:0]  opcode_s;
  logic                  running_s;
  logic [1:0]            sel_a_s;
  logic                  sel_b_s;
  logic                  op_s;
  logic                  wr_acc_s;
  logic                  wr_ram_s;
  logic                  rd_ram_s;
  logic                  illegal_s;

  assign opcode_s  = ir_q[NB_INSTR-1 -: NB_OPCODE];
  assign running_s = (state_q == ST_FETCH) || (state_q == ST_DECODE) || (state_q == ST_EXEC);

  // State, PC, IR and cycle counter registers with synchronous active-low reset
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q  <= ST_IDLE;
      pc_q     <= {NB_ADDR{1'b0}};
      ir_q     <= {NB_INSTR{1'b0}};
      cycles_q <= {NB_CYCLES{1'b0}};
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      cycles_q <= cycles_d;
    end
  end

  // Next-state logic: sequencing, IR capture, PC advance
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.i_start) begin
          state_d = ST_FETCH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FETCH: begin
        state_d = ST_DECODE;
      end
      ST_DECODE: begin
        // Registered ROM presents the word fetched last cycle
        ir_d    = bus.i_instr;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (opcode_s == OP_HLT) begin
          state_d = ST_HALT;
        end else begin
          pc_d    = pc_q + NB_ADDR'(1);
          state_d = ST_FETCH;
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Cycle counter: counts active instruction-cycle clocks, sticks at all-ones
  always_comb begin
    cycles_d = cycles_q;
    if (running_s && (cycles_q != {NB_CYCLES{1'b1}})) begin
      cycles_d = cycles_q + NB_CYCLES'(1);
    end else begin
      cycles_d = cycles_q;
    end
  end

  // Instruction decode; every control stays low outside EXEC
  always_comb begin
    sel_a_s   = SELA_RAM;
    sel_b_s   = 1'b0;
    op_s      = 1'b0;
    wr_acc_s  = 1'b0;
    wr_ram_s  = 1'b0;
    rd_ram_s  = 1'b0;
    illegal_s = 1'b0;
    if (state_q == ST_EXEC) begin
      case (opcode_s)
        OP_HLT: begin
          sel_a_s = SELA_RAM;
        end
        OP_STO: begin
          wr_ram_s = 1'b1;
        end
        OP_LD: begin
          wr_acc_s = 1'b1;
          rd_ram_s = 1'b1;
        end
        OP_LDI: begin
          sel_a_s  = SELA_IMM;
          wr_acc_s = 1'b1;
        end
        OP_ADD: begin
          sel_a_s  = SELA_ALU;
          wr_acc_s = 1'b1;
          rd_ram_s = 1'b1;
        end
        OP_ADDI: begin
          sel_a_s  = SELA_ALU;
          sel_b_s  = 1'b1;
          wr_acc_s = 1'b1;
        end
        OP_SUB: begin
          sel_a_s  = SELA_ALU;
          op_s     = 1'b1;
          wr_acc_s = 1'b1;
          rd_ram_s = 1'b1;
        end
        OP_SUBI: begin
          sel_a_s  = SELA_ALU;
          sel_b_s  = 1'b1;
          op_s     = 1'b1;
          wr_acc_s = 1'b1;
        end
        default: begin
          // Undefined opcode executes as a NOP but is flagged
          illegal_s = 1'b1;
        end
      endcase
    end else begin
      illegal_s = 1'b0;
    end
  end

  assign bus.o_pc      = pc_q;
  assign bus.o_operand = ir_q[NB_OPERAND-1:0];
  assign bus.o_SelA    = sel_a_s;
  assign bus.o_SelB    = sel_b_s;
  assign bus.o_op      = op_s;
  assign bus.o_WrAcc   = wr_acc_s;
  assign bus.o_WrRam   = wr_ram_s;
  assign bus.o_RdRam   = rd_ram_s;
  assign bus.o_halt    = (state_q == ST_HALT);
  assign bus.o_illegal = illegal_s;
  assign bus.o_cycles  = cycles_q;

endmodule

// File: tb/tb_bip_control_unit.sv
// Directed bench for bip_control_unit with a registered program ROM and a small
// accumulator datapath attached so stored results can be observed.
module tb_bip_control_unit;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  logic [15:0] rom [0:2047];
  logic [15:0] ram [0:2047];
  logic [15:0] acc;
  logic [15:0] sx_s;
  logic [15:0] mux_b_s;
  logic [15:0] alu_s;
  logic [15:0] mux_a_s;

  bip_control_unit_if bif ();

  bip_control_unit dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered program ROM: word valid one cycle after o_pc
  always_ff @(posedge clk) begin
    bif.i_instr <= rom[bif.o_pc];
  end

  // Reference accumulator datapath with async-read RAM
  assign sx_s    = {{5{bif.o_operand[10]}}, bif.o_operand};
  assign mux_b_s = bif.o_SelB ? sx_s : ram[bif.o_operand];
  assign alu_s   = bif.o_op ? (acc - mux_b_s) : (acc + mux_b_s);
  assign mux_a_s = (bif.o_SelA == 2'b00) ? ram[bif.o_operand] :
                   (bif.o_SelA == 2'b01) ? sx_s : alu_s;

  always_ff @(posedge clk) begin
    if (!rst) begin
      acc <= 16'd0;
    end else begin
      if (bif.o_WrAcc) acc <= mux_a_s;
      if (bif.o_WrRam) ram[bif.o_operand] <= acc;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] ctrl_now();
    return {bif.o_SelA, bif.o_SelB, bif.o_op, bif.o_WrAcc, bif.o_WrRam,
            bif.o_RdRam, bif.o_illegal};
  endfunction

  task automatic fill_rom(input logic [15:0] word);
    for (int i = 0; i < 2048; i++) begin
      rom[i] = word;
      ram[i] = 16'd0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    bif.i_start = 1'b0;
    step(3);
    rst = 1'b1;
  endtask

  // Control vectors {SelA, SelB, op, WrAcc, WrRam, RdRam, illegal}
  localparam logic [7:0] C_NONE = 8'b00_0_0_0_0_0_0;
  localparam logic [7:0] C_LDI  = 8'b01_0_0_1_0_0_0;
  localparam logic [7:0] C_ADDI = 8'b10_1_0_1_0_0_0;
  localparam logic [7:0] C_STO  = 8'b00_0_0_0_1_0_0;
  localparam logic [7:0] C_SUB  = 8'b10_0_1_1_0_1_0;
  localparam logic [7:0] C_ILL  = 8'b00_0_0_0_0_0_1;

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b0;
    bif.i_start = 1'b0;
    fill_rom(16'h0000);

    // 1: reset held with i_start high
    bif.i_start = 1'b1;
    step(3);
    check("rst_pc", 32'(bif.o_pc), 32'd0);
    check("rst_ctrl", 32'(ctrl_now()), 32'(C_NONE));
    check("rst_cycles", bif.o_cycles, 32'd0);
    check("rst_halt", 32'(bif.o_halt), 32'd0);
    check("rst_operand", 32'(bif.o_operand), 32'd0);

    // 2: LDI 5; ADDI 3; STO 7; HLT
    fill_rom(16'h0000);
    rom[0] = 16'h1805;
    rom[1] = 16'h2803;
    rom[2] = 16'h0807;
    rom[3] = 16'h0000;
    do_reset();
    bif.i_start = 1'b1;
    step(3);
    check("p_ldi_ctrl", 32'(ctrl_now()), 32'(C_LDI));
    check("p_ldi_operand", 32'(bif.o_operand), 32'd5);
    step(3);
    check("p_addi_ctrl", 32'(ctrl_now()), 32'(C_ADDI));
    check("p_addi_pc", 32'(bif.o_pc), 32'd1);
    step(3);
    check("p_sto_ctrl", 32'(ctrl_now()), 32'(C_STO));
    check("p_sto_operand", 32'(bif.o_operand), 32'd7);
    step(3);
    check("p_hlt_ctrl", 32'(ctrl_now()), 32'(C_NONE));
    check("p_hlt_nohalt_yet", 32'(bif.o_halt), 32'd0);
    step(1);
    check("p_halt", 32'(bif.o_halt), 32'd1);
    check("p_halt_pc", 32'(bif.o_pc), 32'd3);
    check("p_halt_cycles", bif.o_cycles, 32'd12);
    check("p_ram7", 32'(ram[7]), 32'd8);
    step(6);
    check("p_halt_hold", 32'(bif.o_halt), 32'd1);
    check("p_halt_cycles_frozen", bif.o_cycles, 32'd12);
    check("p_halt_pc_frozen", 32'(bif.o_pc), 32'd3);

    // 3: idle while i_start low, then leave IDLE on the first high clock
    do_reset();
    step(10);
    check("idle_pc", 32'(bif.o_pc), 32'd0);
    check("idle_cycles", bif.o_cycles, 32'd0);
    check("idle_ctrl", 32'(ctrl_now()), 32'(C_NONE));
    bif.i_start = 1'b1;
    step(1);
    check("start_cycles0", bif.o_cycles, 32'd0);
    step(1);
    check("start_cycles1", bif.o_cycles, 32'd1);
    step(1);
    check("start_exec_ctrl", 32'(ctrl_now()), 32'(C_LDI));

    // 5: undefined opcode then LDI 9 at PC+1
    fill_rom(16'h0000);
    rom[0] = 16'hF800;
    rom[1] = 16'h1809;
    do_reset();
    bif.i_start = 1'b1;
    step(3);
    check("ill_ctrl", 32'(ctrl_now()), 32'(C_ILL));
    step(1);
    check("ill_pulse_end", 32'(ctrl_now()), 32'(C_NONE));
    check("ill_pc", 32'(bif.o_pc), 32'd1);
    step(2);
    check("ill_next_ctrl", 32'(ctrl_now()), 32'(C_LDI));
    check("ill_next_operand", 32'(bif.o_operand), 32'd9);

    // 6: reset asserted during EXEC of SUB 4
    fill_rom(16'h0000);
    rom[0] = 16'h3004;
    do_reset();
    bif.i_start = 1'b1;
    step(3);
    check("sub_ctrl", 32'(ctrl_now()), 32'(C_SUB));
    rst = 1'b0;
    bif.i_start = 1'b0;
    step(1);
    check("midrst_ctrl", 32'(ctrl_now()), 32'(C_NONE));
    check("midrst_pc", 32'(bif.o_pc), 32'd0);
    check("midrst_cycles", bif.o_cycles, 32'd0);
    rst = 1'b1;
    step(2);
    check("midrst_stays_idle", bif.o_cycles, 32'd0);

    // 4: PC wrap after 2048 ADDI 0 instructions
    fill_rom(16'h2800);
    do_reset();
    bif.i_start = 1'b1;
    step(3 * 2048);
    check("wrap_pc_top", 32'(bif.o_pc), 32'd2047);
    check("wrap_exec_ctrl", 32'(ctrl_now()), 32'(C_ADDI));
    step(1);
    check("wrap_pc_zero", 32'(bif.o_pc), 32'd0);
    check("wrap_no_halt", 32'(bif.o_halt), 32'd0);
    check("wrap_cycles", bif.o_cycles, 32'd6144);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
